rtc_timer_core: RTL and testbench

//  Parametrised real-time clock / interval timer on a single clock domain.
//  A prescaler turns clk_125MHz into a one-cycle 1 Hz enable; it does not generate a derived clock.
//  The enable advances an HH:MM:SS counter. In TIMER mode the block also asserts a sticky done at a programmable timeout.

---
 rtl/rtc_pkg.sv | 24 ++
 rtl/rtc_prescaler.sv | 48 ++++
 rtl/rtc_timer_core.sv | 151 +++++++++++++++
 tb/tb_rtc_timer_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared widths, limits and mode encoding for the RTC/interval timer
//
// Purpose : constants used by rtc_timer_core and rtc_prescaler.
// Contents: field widths, per-field maxima, mode encoding, load saturation helper.
package rtc_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_TIMER = 1'b1
  } rtc_mode_e;

  // Clamp a 6-bit load value to 0..59.
  function automatic logic [5:0] sat59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtl/rtc_prescaler.sv - divides the system clock down to a once-per-second strobe
//
// Purpose : counts 0..CLK_HZ-1 while enabled; holds its value while disabled.
// Ports   : clk_125MHz  system clock
//           rst         synchronous active-high reset
//           en          count enable (run state, already gated by stop/clear)
//           clr         zero the count
//           tick        high in the cycle the count sits at its terminal value
//                       while enabled, i.e. the next edge wraps to 0
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 125_000_000
) (
  input  logic clk_125MHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Combinational so the top can register tick_1hz and advance the time
  // counters on the very edge where the prescaler wraps.
  assign tick = en && !clr && (presc_q == TERM);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == TERM) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/rtc_timer_core.sv
// rtl/rtc_timer_core.sv - HH:MM:SS real-time clock with TIMER-mode sticky timeout
//
// Purpose : run-state flop, cascaded sec/min/hr counters, elapsed-seconds
//           counter, sticky done and the load path; prescaler is a sub-module.
// Ports   : clk_125MHz           system clock
//           rst                  synchronous active-high reset
//           start / stop         set / clear run state (stop wins)
//           clear                zero time, prescaler, elapsed, done
//           mode                 0 = CLOCK, 1 = TIMER
//           load, ld_sec/min/hr  load time while stopped (values saturate)
//           tick_1hz             one-cycle pulse per second
//           sec, min, hr         current time
//           elapsed              seconds counted since start/clear (saturating)
//           running, done        run state, sticky TIMER timeout
module rtc_timer_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ      = 125_000_000,
  parameter int TIMEOUT_SEC = 180,
  parameter int HR_MAX      = 23,
  parameter int ELAPSED_W   = 17
) (
  input  logic                 clk_125MHz,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 mode,
  input  logic                 load,
  input  logic [SEC_W-1:0]     ld_sec,
  input  logic [MIN_W-1:0]     ld_min,
  input  logic [HR_W-1:0]      ld_hr,
  output logic                 tick_1hz,
  output logic [SEC_W-1:0]     sec,
  output logic [MIN_W-1:0]     min,
  output logic [HR_W-1:0]      hr,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 running,
  output logic                 done
);

  localparam logic [HR_W-1:0]      HR_LAST   = HR_W'(HR_MAX);
  localparam logic [ELAPSED_W-1:0] EL_MAX    = '1;
  localparam logic [ELAPSED_W-1:0] TIMEOUT_V = ELAPSED_W'(TIMEOUT_SEC);

  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 tick_q, tick_d;
  logic [SEC_W-1:0]     sec_q, sec_d;
  logic [MIN_W-1:0]     min_q, min_d;
  logic [HR_W-1:0]      hr_q, hr_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic [ELAPSED_W-1:0] elapsed_inc;
  logic                 count_en;
  logic                 wrap;

  // Counting uses the current run state; start only takes effect next edge,
  // while stop/clear block the count in the same cycle they are asserted.
  assign count_en = running_q && !stop && !clear;

  rtc_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk_125MHz(clk_125MHz),
    .rst       (rst),
    .en        (count_en),
    .clr       (clear),
    .tick      (wrap)
  );

  assign elapsed_inc = (elapsed_q == EL_MAX) ? elapsed_q : elapsed_q + 1'b1;

  always_comb begin
    running_d = running_q;
    done_d    = done_q;
    tick_d    = 1'b0;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    elapsed_d = elapsed_q;

    if (clear) begin
      // Run state is kept so a running clock restarts from zero.
      sec_d     = '0;
      min_d     = '0;
      hr_d      = '0;
      elapsed_d = '0;
      done_d    = 1'b0;
    end else begin
      if (stop) begin
        running_d = 1'b0;
      end else if (start && !done_q) begin
        running_d = 1'b1;
      end

      if (wrap) begin
        tick_d    = 1'b1;
        elapsed_d = elapsed_inc;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d = '0;
            hr_d  = (hr_q == HR_LAST) ? '0 : hr_q + 1'b1;
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
        // Timeout is judged on the mode in force at this tick.
        if (mode == MODE_TIMER && elapsed_inc == TIMEOUT_V) begin
          done_d    = 1'b1;
          running_d = 1'b0;
        end
      end else if (load && !running_q && !stop && !start) begin
        sec_d = sat59(ld_sec);
        min_d = sat59(ld_min);
        hr_d  = (ld_hr > HR_LAST) ? HR_LAST : ld_hr;
      end
    end
  end

  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      elapsed_q <= '0;
    end else begin
      running_q <= running_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign tick_1hz = tick_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hr       = hr_q;
  assign elapsed  = elapsed_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rtc_timer_core.sv
// tb/tb_rtc_timer_core.sv - scoreboard bench for rtc_timer_core
module tb_rtc_timer_core;

  localparam int CLK_HZ      = 4;
  localparam int TIMEOUT_SEC = 3;
  localparam int HR_MAX      = 23;
  localparam int ELAPSED_W   = 17;
  localparam int EL_MAX      = (1 << ELAPSED_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst, start, stop, clear, mode, load;
  logic [5:0]           ld_sec, ld_min;
  logic [4:0]           ld_hr;
  logic                 tick_1hz, running, done;
  logic [5:0]           sec, min;
  logic [4:0]           hr;
  logic [ELAPSED_W-1:0] elapsed;

  rtc_timer_core #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_SEC(TIMEOUT_SEC),
    .HR_MAX     (HR_MAX),
    .ELAPSED_W  (ELAPSED_W)
  ) dut (
    .clk_125MHz(clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode      (mode),
    .load      (load),
    .ld_sec    (ld_sec),
    .ld_min    (ld_min),
    .ld_hr     (ld_hr),
    .tick_1hz  (tick_1hz),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .elapsed   (elapsed),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tick, s, m, h, el, run, dn;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_ticks  = 0;
  int last_tick = 0;
  bit track    = 1'b0;

  // Reference state
  int m_presc = 0, m_tick = 0, m_s = 0, m_m = 0, m_h = 0, m_el = 0, m_run = 0, m_dn = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  // One clock edge of the behavioural model, driven from the current inputs.
  task automatic model_step();
    int nrun;
    if (rst) begin
      m_presc = 0; m_tick = 0; m_s = 0; m_m = 0; m_h = 0; m_el = 0; m_run = 0; m_dn = 0;
    end else begin
      m_tick = 0;
      nrun = m_run;
      if (clear) begin
        m_presc = 0; m_s = 0; m_m = 0; m_h = 0; m_el = 0; m_dn = 0;
      end else begin
        if (stop) nrun = 0;
        else if (start && !m_dn) nrun = 1;
        if (m_run && !stop) begin
          if (m_presc == CLK_HZ - 1) begin
            m_presc = 0;
            m_tick  = 1;
            m_s = m_s + 1;
            if (m_s == 60) begin
              m_s = 0;
              m_m = m_m + 1;
              if (m_m == 60) begin
                m_m = 0;
                m_h = (m_h == HR_MAX) ? 0 : m_h + 1;
              end
            end
            if (m_el < EL_MAX) m_el = m_el + 1;
            if (mode && m_el == TIMEOUT_SEC) begin
              m_dn = 1;
              nrun = 0;
            end
          end else begin
            m_presc = m_presc + 1;
          end
        end else if (load && !m_run && !stop && !start) begin
          m_s = (int'(ld_sec) > 59) ? 59 : int'(ld_sec);
          m_m = (int'(ld_min) > 59) ? 59 : int'(ld_min);
          m_h = (int'(ld_hr) > HR_MAX) ? HR_MAX : int'(ld_hr);
        end
      end
      m_run = nrun;
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    e.tick = m_tick; e.s = m_s; e.m = m_m; e.h = m_h; e.el = m_el; e.run = m_run; e.dn = m_dn;
    sb.push_back(e);
    #1;
    cyc++;
    e = sb.pop_front();
    check_eq("sb_tick", int'(tick_1hz), e.tick);
    check_eq("sb_sec", int'(sec), e.s);
    check_eq("sb_min", int'(min), e.m);
    check_eq("sb_hr", int'(hr), e.h);
    check_eq("sb_elapsed", int'(elapsed), e.el);
    check_eq("sb_running", int'(running), e.run);
    check_eq("sb_done", int'(done), e.dn);
    if (tick_1hz && track) begin
      n_ticks++;
      check_eq("t1_tick_spacing", cyc - last_tick, CLK_HZ);
      last_tick = cyc;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0; load = 1'b0;
    ld_sec = '0; ld_min = '0; ld_hr = '0;
    #1;
    cycle(); cycle();
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_tick", int'(tick_1hz), 0);
    check_eq("rst_time", int'({hr, min, sec}), 0);
    rst = 1'b0;

    // 1: 240 cycles of CLOCK mode -> 60 ticks, 00:01:00
    start = 1'b1; cycle(); start = 1'b0;
    n_ticks = 0; last_tick = cyc; track = 1'b1;
    repeat (240) cycle();
    track = 1'b0;
    check_eq("t1_tick_count", n_ticks, 60);
    check_eq("t1_sec", int'(sec), 0);
    check_eq("t1_min", int'(min), 1);

    // 2: hour/day wrap from 23:59:58
    stop = 1'b1; cycle(); stop = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    load = 1'b1; ld_sec = 6'd58; ld_min = 6'd59; ld_hr = 5'd23; cycle(); load = 1'b0;
    check_eq("t2_load_sec", int'(sec), 58);
    check_eq("t2_load_hr", int'(hr), 23);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    check_eq("t2_wrap_time", int'({hr, min, sec}), 0);
    check_eq("t2_no_done", int'(done), 0);

    // 3: TIMER timeout at the third tick
    stop = 1'b1; cycle(); stop = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    mode = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (11) cycle();
    check_eq("t3_done_early", int'(done), 0);
    cycle();
    check_eq("t3_done", int'(done), 1);
    check_eq("t3_stopped", int'(running), 0);
    check_eq("t3_sec", int'(sec), 3);
    repeat (8) cycle();
    check_eq("t3_sec_frozen", int'(sec), 3);
    start = 1'b1; cycle(); start = 1'b0;
    check_eq("t3_start_ignored", int'(running), 0);
    clear = 1'b1; cycle(); clear = 1'b0;
    check_eq("t3_clear_done", int'(done), 0);
    mode = 1'b0;

    // 4: start+stop together; stop freezes prescaler mid-second
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check_eq("t4_stop_wins", int'(running), 0);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (2) cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (5) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check_eq("t4_no_tick_yet", int'(tick_1hz), 0);
    cycle();
    check_eq("t4_tick_after_2", int'(tick_1hz), 1);

    // 5: load ignored while running; saturating load while stopped
    load = 1'b1; ld_sec = 6'd30; ld_min = 6'd20; ld_hr = 5'd10; cycle(); load = 1'b0;
    check_eq("t5_run_load_sec", int'(sec), 1);
    check_eq("t5_run_load_hr", int'(hr), 0);
    stop = 1'b1; cycle(); stop = 1'b0;
    load = 1'b1; ld_sec = 6'd63; ld_min = 6'd60; ld_hr = 5'd31; cycle(); load = 1'b0;
    check_eq("t5_sat_sec", int'(sec), 59);
    check_eq("t5_sat_min", int'(min), 59);
    check_eq("t5_sat_hr", int'(hr), HR_MAX);

    // 6: rst mid-count with start held
    start = 1'b1; cycle();
    repeat (6) cycle();
    rst = 1'b1; cycle();
    check_eq("t6_rst_running", int'(running), 0);
    check_eq("t6_rst_time", int'({hr, min, sec}), 0);
    check_eq("t6_rst_elapsed", int'(elapsed), 0);
    rst = 1'b0; cycle();
    check_eq("t6_run_after_rst", int'(running), 1);
    start = 1'b0;

    // Random mix of all controls against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      start = ($urandom_range(0, 7) == 0);
      load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      ld_sec = 6'($urandom_range(0, 63));
      ld_min = 6'($urandom_range(0, 63));
      ld_hr  = 5'($urandom_range(0, 31));
      cycle();
    end
    rst = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0; load = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
